car_collision_detect: RTL and testbench

Consumer end of the flattened car-position bus driven by the multi-car controller. On request it snapshots all 10 car positions and the frog position, then scans the cars one per clock for overlap with the frog. It reports the result with a done pulse and maintains the player's life counter and game-over flag for the game/VGA logic.

---
 rtl/car_collision_detect.sv | 167 ++++++++++++++++
 tb/tb_car_collision_detect.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/car_collision_detect.sv
// Collision detector: snapshots the car bus and the frog position on request,
// scans the cars one per clock for overlap, and keeps the life counter.
module car_collision_detect #(
    parameter int c_NUM_CARS  = 10,
    parameter int c_CAR_WIDTH = 2,
    parameter int c_LIVES     = 3
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [59:0] i_Car_X,
    input  logic [59:0] i_Car_Y,
    input  logic [5:0]  i_Frog_X,
    input  logic [5:0]  i_Frog_Y,
    input  logic        i_Scan_Start,
    input  logic        i_Lives_Reload,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Hit,
    output logic [3:0]  o_Hit_Car,
    output logic [2:0]  o_Lives,
    output logic        o_Game_Over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_CAR   = 4'(c_NUM_CARS - 1);
    localparam logic [2:0] c_LIVES_INIT = 3'(c_LIVES);

    // Right edge is formed in 7 bits so a car near X = 63 cannot wrap to a small value.
    function automatic logic car_overlaps(input logic [5:0] car_x, input logic [5:0] car_y,
                                          input logic [5:0] frog_x, input logic [5:0] frog_y);
        logic [6:0] right_edge;
        right_edge = {1'b0, car_x} + 7'(c_CAR_WIDTH);
        return (car_y == frog_y) && (car_x <= frog_x) && ({1'b0, frog_x} < right_edge);
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  idx_r, idx_s;
    logic        hit_r, hit_s;
    logic [3:0]  hit_car_r, hit_car_s;
    logic        load_s;
    logic [59:0] snap_x_r, snap_y_r;
    logic [5:0]  frog_x_r, frog_y_r;
    logic [5:0]  cur_x_s, cur_y_s;
    logic        cur_hit_s;
    logic [2:0]  lives_s;

    // Select the snapshot entry of the car under test.
    always_comb begin
        cur_x_s = 6'd0;
        cur_y_s = 6'd0;
        for (int k = 0; k < c_NUM_CARS; k++) begin
            cur_x_s = (idx_r == 4'(k)) ? snap_x_r[k*6 +: 6] : cur_x_s;
            cur_y_s = (idx_r == 4'(k)) ? snap_y_r[k*6 +: 6] : cur_y_s;
        end
        cur_hit_s = car_overlaps(cur_x_s, cur_y_s, frog_x_r, frog_y_r);
    end

    // Next-state logic for the scan sequencer.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        hit_s     = hit_r;
        hit_car_s = hit_car_r;
        load_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_Scan_Start) begin
                    load_s    = 1'b1;
                    idx_s     = 4'd0;
                    hit_s     = 1'b0;
                    hit_car_s = 4'd0;
                    state_s   = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (cur_hit_s) begin
                    hit_s     = 1'b1;
                    hit_car_s = idx_r;
                    state_s   = REPORT;
                end else if (idx_r == c_LAST_CAR) begin
                    hit_s     = 1'b0;
                    hit_car_s = 4'd0;
                    state_s   = REPORT;
                end else begin
                    idx_s = idx_r + 4'd1;
                end
            end
            REPORT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Reload has priority over the hit decrement; the counter saturates at zero.
    always_comb begin
        lives_s = o_Lives;
        if (i_Lives_Reload) begin
            lives_s = c_LIVES_INIT;
        end else if ((state_r == REPORT) && hit_r && (o_Lives != 3'd0)) begin
            lives_s = o_Lives - 3'd1;
        end else begin
            lives_s = o_Lives;
        end
    end

    // Sequencer state, scan index and pending result.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r   <= IDLE;
            idx_r     <= 4'd0;
            hit_r     <= 1'b0;
            hit_car_r <= 4'd0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            hit_r     <= hit_s;
            hit_car_r <= hit_car_s;
        end
    end

    // Snapshot of the bus and frog, taken only when a scan is accepted.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            snap_x_r <= 60'd0;
            snap_y_r <= 60'd0;
            frog_x_r <= 6'd0;
            frog_y_r <= 6'd0;
        end else if (load_s) begin
            snap_x_r <= i_Car_X;
            snap_y_r <= i_Car_Y;
            frog_x_r <= i_Frog_X;
            frog_y_r <= i_Frog_Y;
        end
    end

    // Registered status and result outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Hit       <= 1'b0;
            o_Hit_Car   <= 4'd0;
            o_Lives     <= c_LIVES_INIT;
            o_Game_Over <= 1'b0;
        end else begin
            o_Busy      <= (state_s != IDLE);
            o_Done      <= (state_r == REPORT);
            o_Lives     <= lives_s;
            o_Game_Over <= (lives_s == 3'd0);
            if (state_r == REPORT) begin
                o_Hit     <= hit_r;
                o_Hit_Car <= hit_car_r;
            end
        end
    end

endmodule

// File: tb/tb_car_collision_detect.sv
// Self-checking bench: directed scenarios plus randomized scans against a
// behavioural model of the overlap rule, scan latency and life counter.
module tb_car_collision_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [59:0] car_x = 60'd0;
    logic [59:0] car_y = 60'd0;
    logic [5:0]  frog_x = 6'd0;
    logic [5:0]  frog_y = 6'd0;
    logic        scan_start = 1'b0;
    logic        lives_reload = 1'b0;
    logic        busy, done, hit;
    logic [3:0]  hit_car;
    logic [2:0]  lives;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    int cx[10];
    int cy[10];
    int m_lives = 3;

    car_collision_detect dut (
        .i_Clk(clk), .i_Rst(rst), .i_Car_X(car_x), .i_Car_Y(car_y),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Scan_Start(scan_start),
        .i_Lives_Reload(lives_reload), .o_Busy(busy), .o_Done(done), .o_Hit(hit),
        .o_Hit_Car(hit_car), .o_Lives(lives), .o_Game_Over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // First car (lowest index) whose row matches and whose span covers the frog.
    function automatic void ref_scan(input int fx, input int fy, output int h, output int c);
        h = 0;
        c = 0;
        for (int k = 0; k < 10; k++) begin
            if (h == 0 && cy[k] == fy && cx[k] <= fx && fx < cx[k] + 2) begin
                h = 1;
                c = k;
            end
        end
    endfunction

    task automatic drive_bus();
        for (int k = 0; k < 10; k++) begin
            car_x[k*6 +: 6] = 6'(cx[k]);
            car_y[k*6 +: 6] = 6'(cy[k]);
        end
    endtask

    task automatic set_diag_cars();
        for (int k = 0; k < 10; k++) begin
            cx[k] = k + 1;
            cy[k] = k + 1;
        end
    endtask

    task automatic reload_idle(input string tag);
        @(negedge clk);
        lives_reload = 1'b1;
        @(negedge clk);
        lives_reload = 1'b0;
        m_lives = 3;
        check({tag, "_lives"}, 32'(lives), 32'(m_lives));
        check({tag, "_gameover"}, 32'(game_over), 32'd0);
    endtask

    task automatic run_scan(input string tag, input int fx, input int fy,
                            input bit perturb, input bit restart, input bit reload_rep);
        int eh, ec, elat, lat, extra;
        ref_scan(fx, fy, eh, ec);
        elat = (eh != 0) ? ec + 2 : 11;
        drive_bus();
        frog_x = 6'(fx);
        frog_y = 6'(fy);
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        lat = 0;
        if (perturb) begin
            for (int k = 0; k < 10; k++) begin
                car_x[k*6 +: 6] = 6'(fx);
                car_y[k*6 +: 6] = 6'(fy);
            end
        end
        while (!done && lat < 40) begin
            if (lat == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            scan_start   = (restart && lat == 1);
            lives_reload = (reload_rep && lat == elat - 1);
            @(negedge clk);
            lat++;
        end
        scan_start   = 1'b0;
        lives_reload = 1'b0;
        if (reload_rep) m_lives = 3;
        else if (eh != 0 && m_lives > 0) m_lives--;
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_hit"}, 32'(hit), 32'(eh));
        check({tag, "_hitcar"}, 32'(hit_car), 32'(ec));
        check({tag, "_lives"}, 32'(lives), 32'(m_lives));
        check({tag, "_gameover"}, 32'(game_over), 32'(m_lives == 0));
        @(negedge clk);
        check({tag, "_donepulse"}, 32'(done), 32'd0);
        check({tag, "_hithold"}, 32'(hit), 32'(eh));
        if (restart) begin
            extra = 0;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check({tag, "_nodup"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int fx, fy, sel, extra;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_gameover", 32'(game_over), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);

        set_diag_cars();
        run_scan("miss_all", 15, 30, 1'b0, 1'b0, 1'b0);
        run_scan("hit_car2", 4, 3, 1'b0, 1'b0, 1'b0);
        run_scan("edge_right", 5, 3, 1'b0, 1'b0, 1'b0);
        run_scan("edge_left", 2, 3, 1'b0, 1'b0, 1'b0);
        run_scan("edge_exact", 3, 3, 1'b0, 1'b0, 1'b0);
        reload_idle("reload1");

        cx[4] = 6; cy[4] = 20;
        cx[7] = 6; cy[7] = 20;
        run_scan("overlap", 6, 20, 1'b1, 1'b1, 1'b0);

        reload_idle("reload2");
        for (int i = 0; i < 4; i++) run_scan("consec", 6, 20, 1'b0, 1'b0, 1'b0);
        run_scan("reload_rep", 6, 20, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            fx = $urandom_range(0, 63);
            fy = $urandom_range(0, 20);
            for (int k = 0; k < 10; k++) begin
                sel = $urandom_range(0, 3);
                if (sel == 0) cx[k] = $urandom_range(0, 63);
                else if (sel == 1) cx[k] = fx;
                else if (sel == 2) cx[k] = (fx > 0) ? fx - 1 : 63;
                else cx[k] = 63;
                cy[k] = ($urandom_range(0, 3) == 0) ? fy : $urandom_range(0, 20);
            end
            if (m_lives == 0 && $urandom_range(0, 1) == 1) reload_idle("rand_reload");
            run_scan("rand", fx, fy, 1'b0, 1'b0, 1'b0);
        end

        reload_idle("reload3");
        set_diag_cars();
        run_scan("pre_rst_hit", 4, 3, 1'b0, 1'b0, 1'b0);
        drive_bus();
        frog_x = 6'd15;
        frog_y = 6'd30;
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (3) @(negedge clk);
        check("midscan_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_hit", 32'(hit), 32'd0);
        check("arst_hitcar", 32'(hit_car), 32'd0);
        check("arst_lives", 32'(lives), 32'd3);
        check("arst_gameover", 32'(game_over), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("arst_nodone", 32'(extra), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
